// File: rtl/axi_slv_pkg.sv
// Shared types and helpers for the AXI slave memory endpoint.
//   burst_e      : AXI burst encoding (FIXED/INCR/WRAP/RSVD)
//   OKAY/SLVERR  : response codes
//   W_* / R_*    : write and read FSM state constants
//   addr_next()  : beat-to-beat address update for all burst types
package axi_slv_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Next beat address. WRAP keeps the upper bits of the aligned window and
    // lets only the low bits roll over; the window is a power of two whenever
    // LEN is legal, and an illegal LEN marks the burst as an error anyway.
    // RSVD steps like INCR.
    function automatic logic [63:0] addr_next(input logic [63:0] addr,
                                              input logic [2:0]  size,
                                              input logic [3:0]  len,
                                              input burst_e      burst);
        logic [63:0] step;
        logic [63:0] mask;
        logic [63:0] nxt;
        step = 64'd1 << size;
        mask = ((64'(len) + 64'd1) << size) - 64'd1;
        nxt  = addr + step;
        case (burst)
            FIXED:   addr_next = addr;
            WRAP:    addr_next = (addr & ~mask) | (nxt & mask);
            default: addr_next = nxt;
        endcase
    endfunction

endpackage

// File: rtl/axi_slv_mem.sv
// Byte-enabled dual-port RAM: one write port, one synchronous read port.
//   clk_i           : clock
//   we_i/waddr_i    : write enable and word index
//   wdata_i/wstrb_i : write data and per-byte enables
//   re_i/raddr_i    : read enable and word index
//   rdata_o         : registered read data, held while re_i is low
// A read and a write to the same word in one cycle return the old word.
module axi_slv_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024,
    parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    re_i,
    input  logic [IDX_W-1:0]        raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [0:MEM_DEPTH-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (we_i && wstrb_i[b]) begin
                mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_slave_modport_mem.sv
// AXI3-style slave with a word-addressed internal memory.
//   clk, rst            : clock, synchronous active-high reset
//   AW*/W*/B*           : write address, write data, write response channels
//   AR*/R*              : read address and read data channels
//   wr_state_o/rd_state_o : current write / read FSM state (debug)
// Handshake rule on every channel: a transfer happens on a rising edge where
// VALID and READY are both high; a VALID source holds its payload stable
// until that edge and never waits on READY before raising VALID.
// Write (AW/W/B) and read (AR/R) paths are independent FSMs sharing one RAM.
module axi_slave_modport_mem
    import axi_slv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [3:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [3:0]              WID,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [3:0]              BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [3:0]              ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [3:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [3:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [3:0]              RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [1:0]              wr_state_o,
    output logic                    rd_state_o
);
    localparam int LSB   = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] AX_ONE = 1;

    // Burst-level field errors, known at the address handshake.
    function automatic logic fields_bad(input logic [2:0] size, input logic [3:0] len,
                                        input burst_e burst);
        return (size > 3'(LSB)) || (burst == RSVD) ||
               ((burst == WRAP) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    endfunction

    // Highest byte any beat can touch; if its word is out of range the whole
    // burst is an error, so no beat is written before the problem is known.
    function automatic logic range_bad(input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] size,
                                       input logic [3:0] len, input burst_e burst);
        logic [ADDR_WIDTH:0] a;
        logic [ADDR_WIDTH:0] win;
        logic [ADDR_WIDTH:0] last;
        a   = {1'b0, addr};
        win = ((ADDR_WIDTH+1)'(len) + AX_ONE) << size;
        case (burst)
            FIXED:   last = a;
            WRAP:    last = (a & ~(win - AX_ONE)) + win - AX_ONE;
            default: last = a + ((ADDR_WIDTH+1)'(len) << size);
        endcase
        return (last >> LSB) >= (ADDR_WIDTH+1)'(MEM_DEPTH);
    endfunction

    // ---------------- write path ----------------
    logic [1:0]            w_state_q;
    logic                  awready_q, wready_q, bvalid_q;
    logic [3:0]            bid_q, w_id_q, w_len_q, w_cnt_q;
    logic [1:0]            bresp_q;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [2:0]            w_size_q;
    burst_e                w_burst_q;
    logic                  w_err_q, w_last_err_q;
    logic                  w_beat, w_is_last, w_last_mismatch, mem_we;

    assign w_addr_d        = ADDR_WIDTH'(addr_next(64'(w_addr_q), w_size_q, w_len_q, w_burst_q));
    assign w_beat          = (w_state_q == W_DATA) && WVALID && wready_q;
    assign w_is_last       = (w_cnt_q == w_len_q);
    assign w_last_mismatch = (WLAST != w_is_last);
    assign mem_we          = w_beat && !w_err_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q    <= W_IDLE;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bid_q        <= '0;
            bresp_q      <= OKAY;
            w_id_q       <= '0;
            w_addr_q     <= '0;
            w_len_q      <= '0;
            w_size_q     <= '0;
            w_burst_q    <= FIXED;
            w_cnt_q      <= '0;
            w_err_q      <= 1'b0;
            w_last_err_q <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (AWVALID && awready_q) begin
                        awready_q    <= 1'b0;
                        wready_q     <= 1'b1;
                        w_id_q       <= AWID;
                        w_addr_q     <= AWADDR;
                        w_len_q      <= AWLEN;
                        w_size_q     <= AWSIZE;
                        w_burst_q    <= burst_e'(AWBURST);
                        w_cnt_q      <= '0;
                        w_err_q      <= fields_bad(AWSIZE, AWLEN, burst_e'(AWBURST)) ||
                                        range_bad(AWADDR, AWSIZE, AWLEN, burst_e'(AWBURST));
                        w_last_err_q <= 1'b0;
                        w_state_q    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_addr_q <= w_addr_d;
                        w_cnt_q  <= w_cnt_q + 4'd1;
                        if (w_last_mismatch) begin
                            w_last_err_q <= 1'b1;
                        end
                        if (w_is_last) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bid_q     <= w_id_q;
                            bresp_q   <= (w_err_q || w_last_err_q || w_last_mismatch) ? SLVERR : OKAY;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_q  <= 1'b0;
                        bid_q     <= '0;
                        bresp_q   <= OKAY;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    logic [0:0]            r_state_q;
    logic                  arready_q, rvalid_q;
    logic [3:0]            r_id_q, r_len_q, r_cnt_q;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [2:0]            r_size_q;
    burst_e                r_burst_q;
    logic                  r_err_q;
    logic                  ar_hs, r_adv, mem_re;
    logic [IDX_W-1:0]      mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign r_addr_d = ADDR_WIDTH'(addr_next(64'(r_addr_q), r_size_q, r_len_q, r_burst_q));
    assign ar_hs    = (r_state_q == R_IDLE) && ARVALID && arready_q;
    assign r_adv    = (r_state_q == R_DATA) && RREADY && (r_cnt_q != r_len_q);
    // The RAM read is issued on the edge that accepts AR or a beat, so the
    // next beat's data is already registered when RVALID shows it.
    assign mem_re    = ar_hs || r_adv;
    assign mem_raddr = ar_hs ? ARADDR[LSB +: IDX_W] : r_addr_d[LSB +: IDX_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= FIXED;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        r_id_q    <= ARID;
                        r_addr_q  <= ARADDR;
                        r_len_q   <= ARLEN;
                        r_size_q  <= ARSIZE;
                        r_burst_q <= burst_e'(ARBURST[1:0]);
                        r_cnt_q   <= '0;
                        r_err_q   <= fields_bad(ARSIZE, ARLEN, burst_e'(ARBURST[1:0])) ||
                                     range_bad(ARADDR, ARSIZE, ARLEN, burst_e'(ARBURST[1:0]));
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        if (r_cnt_q == r_len_q) begin
                            rvalid_q  <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_addr_q <= r_addr_d;
                            r_cnt_q  <= r_cnt_q + 4'd1;
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    axi_slv_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (w_addr_q[LSB +: IDX_W]),
        .wdata_i (WDATA),
        .wstrb_i (WSTRB),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    // WID and the upper ARBURST bits carry no meaning for this slave.
    logic unused_ok;
    assign unused_ok = ^{WID, ARBURST[3:2]};

    assign AWREADY    = awready_q;
    assign WREADY     = wready_q;
    assign BVALID     = bvalid_q;
    assign BID        = bid_q;
    assign BRESP      = bresp_q;
    assign ARREADY    = arready_q;
    assign RVALID     = rvalid_q;
    assign RID        = rvalid_q ? r_id_q : '0;
    assign RDATA      = (rvalid_q && !r_err_q) ? mem_rdata : '0;
    assign RRESP      = (rvalid_q && r_err_q) ? SLVERR : OKAY;
    assign RLAST      = rvalid_q && (r_cnt_q == r_len_q);
    assign wr_state_o = w_state_q;
    assign rd_state_o = r_state_q;

endmodule

// File: tb/tb_axi_slave_modport_mem.sv
module tb_axi_slave_modport_mem;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  AWID, AWLEN, WID, BID, ARID, ARLEN, ARBURST, RID;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, BRESP, RRESP, wr_state_o;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY, rd_state_o;

  axi_slave_modport_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .wr_state_o(wr_state_o), .rd_state_o(rd_state_o)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_mem [0:DEPTH-1];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_strb[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte address of beat i, straight from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [3:0] len, input logic [1:0] burst, input int i);
    longint sz, win, base;
    sz  = longint'(1) << size;
    win = (longint'(len) + 1) * sz;
    case (burst)
      2'b00: return a;
      2'b10: begin
        base = (longint'(a) / win) * win;
        return 32'(base + ((longint'(a) - base + longint'(i) * sz) % win));
      end
      default: return 32'(longint'(a) + longint'(i) * sz);
    endcase
  endfunction

  function automatic logic burst_err(input logic [31:0] a, input logic [2:0] size,
                                     input logic [3:0] len, input logic [1:0] burst);
    logic e;
    e = (size > 3'd2) || (burst == 2'b11) ||
        (burst == 2'b10 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    for (int i = 0; i <= int'(len); i++)
      if ((beat_addr(a, size, len, burst, i) >> 2) >= DEPTH) e = 1'b1;
    return e;
  endfunction

  task automatic push_beat(input logic [31:0] d, input logic [3:0] s);
    wq_data.push_back(d);
    wq_strb.push_back(s);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push_beat($urandom, 4'($urandom_range(0, 15)));
  endtask

  // Called and returns just after a falling edge.
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int bad_last,
                             input int bready_delay, input bit abort_b);
    int n;
    logic err;
    logic [1:0] resp;
    int w;
    err  = burst_err(addr, size, len, burst);
    resp = (err || bad_last >= 0) ? 2'b10 : 2'b00;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("aw_wait", 64'(n < 100), 64'd1);
    @(negedge clk);
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(0, 3) == 0) begin WVALID = 1'b0; @(negedge clk); end
      WID = 4'($urandom); WDATA = wq_data[i]; WSTRB = wq_strb[i];
      WLAST = (i == int'(len)) ^ (i == bad_last); WVALID = 1'b1;
      n = 0;
      while (WREADY !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("w_wait", 64'(n < 100), 64'd1);
      @(negedge clk);
      if (!err) begin
        w = int'(beat_addr(addr, size, len, burst, i) >> 2);
        for (int b = 0; b < 4; b++)
          if (wq_strb[i][b]) model_mem[w][b*8 +: 8] = wq_data[i][b*8 +: 8];
      end
    end
    WVALID = 1'b0; WLAST = 1'b0;
    wq_data.delete(); wq_strb.delete();
    chk("b_valid", BVALID, 1);
    chk("b_id", BID, id);
    chk("b_resp", BRESP, resp);
    if (abort_b) begin
      rst = 1'b1;
      @(negedge clk);
      chk("b_abort", {BVALID, BID, BRESP}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("aw_ready_after_rst", {AWREADY, BVALID}, 2'b10);
    end else begin
      repeat (bready_delay) begin
        @(negedge clk);
        chk("b_hold", {BVALID, BID, BRESP}, {1'b1, id, resp});
      end
      BREADY = 1'b1;
      @(negedge clk);
      BREADY = 1'b0;
      chk("b_done", BVALID, 0);
      chk("aw_ready_after_b", AWREADY, 1);
    end
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit stall);
    int n;
    logic err;
    logic [31:0] d;
    logic last;
    err = burst_err(addr, size, len, burst);
    for (int i = 0; i <= int'(len); i++)
      exp_q.push_back(err ? 32'd0 : model_mem[int'(beat_addr(addr, size, len, burst, i) >> 2)]);
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size;
    ARBURST = {2'($urandom), burst}; ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("ar_wait", 64'(n < 100), 64'd1);
    @(negedge clk);
    ARVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      d = exp_q.pop_front();
      last = (i == int'(len));
      chk("r_valid", RVALID, 1);
      chk("r_data", RDATA, d);
      chk("r_resp", RRESP, err ? 2'b10 : 2'b00);
      chk("r_id", RID, id);
      chk("r_last", RLAST, last);
      if (stall && (i % 2 == 0)) begin
        @(negedge clk);
        chk("r_stall_hold", {RVALID, RLAST, RDATA}, {1'b1, last, d});
      end
      RREADY = 1'b1;
      @(negedge clk);
      RREADY = 1'b0;
    end
    chk("r_idle", RVALID, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d0, d1, keep0;
    logic [2:0]  sz;
    logic [3:0]  ln;
    logic [1:0]  bt;
    int r;
    rst = 1'b1;
    AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0; AWVALID = 0;
    WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0; BREADY = 0;
    ARID = 0; ARADDR = 0; ARLEN = 0; ARSIZE = 0; ARBURST = 0; ARVALID = 0; RREADY = 0;
    repeat (2) @(negedge clk);
    chk("reset_outs", {AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RDATA, RID, RRESP,
                       RLAST, wr_state_o, rd_state_o}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {AWREADY, ARREADY}, 2'b11);

    // Known contents for words 0..95 so every later read has a model value.
    for (int k = 0; k < 6; k++) begin
      push_rand(16);
      for (int i = 0; i < 16; i++) wq_strb[i] = 4'hF;
      write_burst(4'(k), 32'(k * 64), 4'd15, 3'd2, 2'b01, -1, 0, 0);
    end

    // Single write then read.
    push_beat(32'hDEADBEEF, 4'hF);
    write_burst(4'd3, 32'h10, 4'd0, 3'd2, 2'b01, -1, 0, 0);
    read_burst(4'd5, 32'h10, 4'd0, 3'd2, 2'b01, 0);

    // INCR write 1..4, read back with RREADY stalls.
    for (int i = 1; i <= 4; i++) push_beat(32'(i), 4'hF);
    write_burst(4'd7, 32'h20, 4'd3, 3'd2, 2'b01, -1, 2, 0);
    read_burst(4'd8, 32'h20, 4'd3, 3'd2, 2'b01, 1);

    // WRAP read starting mid-window.
    read_burst(4'd9, 32'h38, 4'd3, 3'd2, 2'b10, 0);

    // FIXED write: last beat wins.
    push_beat(32'hAAAA_0001, 4'hF); push_beat(32'hBBBB_0002, 4'hF); push_beat(32'hCCCC_0003, 4'hF);
    write_burst(4'd1, 32'h40, 4'd2, 3'd2, 2'b00, -1, 0, 0);
    read_burst(4'd1, 32'h40, 4'd0, 3'd2, 2'b01, 0);

    // Partial strobe over all-ones.
    push_beat(32'hFFFF_FFFF, 4'hF);
    write_burst(4'd2, 32'h50, 4'd0, 3'd2, 2'b01, -1, 0, 0);
    push_beat(32'h1122_3344, 4'h3);
    write_burst(4'd2, 32'h50, 4'd0, 3'd2, 2'b01, -1, 1, 0);
    read_burst(4'd2, 32'h50, 4'd0, 3'd2, 2'b01, 0);

    // Out-of-range and oversize bursts.
    keep0 = model_mem[0];
    push_beat(32'h5A5A_5A5A, 4'hF);
    write_burst(4'd4, 32'(4 * DEPTH), 4'd0, 3'd2, 2'b01, -1, 0, 0);
    read_burst(4'd4, 32'h0, 4'd0, 3'd2, 2'b01, 0);
    chk("oob_model_unchanged", model_mem[0], keep0);
    read_burst(4'd6, 32'(4 * DEPTH), 4'd1, 3'd2, 2'b01, 0);
    push_beat(32'h1234_5678, 4'hF);
    write_burst(4'd6, 32'h60, 4'd0, 3'd3, 2'b01, -1, 0, 0);
    read_burst(4'd6, 32'h60, 4'd0, 3'd2, 2'b01, 0);

    // WLAST early and WLAST missing.
    push_rand(2);
    write_burst(4'd10, 32'h80, 4'd1, 3'd2, 2'b01, 0, 0, 0);
    push_rand(2);
    write_burst(4'd11, 32'h88, 4'd1, 3'd2, 2'b01, 1, 0, 0);
    read_burst(4'd12, 32'h80, 4'd3, 3'd2, 2'b01, 0);

    // Reset on beat 1 of a 4-beat write.
    d0 = $urandom; d1 = $urandom;
    AWID = 4'd13; AWADDR = 32'h70; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b1;
    chk("mid_aw_ready", AWREADY, 1);
    @(negedge clk);
    AWVALID = 1'b0;
    WDATA = d0; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    chk("mid_w0_ready", WREADY, 1);
    @(negedge clk);
    WDATA = d1;
    chk("mid_w1_ready", WREADY, 1);
    @(negedge clk);
    WVALID = 1'b0;
    model_mem[28] = d0; model_mem[29] = d1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", {AWREADY, WREADY, BVALID, BID, BRESP, ARREADY, RVALID, RDATA, RID, RRESP,
                         RLAST, wr_state_o, rd_state_o}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_aw_ready", {AWREADY, BVALID}, 2'b10);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_no_b", BVALID, 0);
    end
    read_burst(4'd13, 32'h70, 4'd3, 3'd2, 2'b01, 0);

    // Reset while the response is held.
    push_rand(1);
    write_burst(4'd14, 32'h90, 4'd0, 3'd2, 2'b01, -1, 0, 1);
    read_burst(4'd14, 32'h90, 4'd0, 3'd2, 2'b01, 0);

    // Random bursts checked against the model.
    for (int it = 0; it < 40; it++) begin
      a  = 32'($urandom_range(0, 255));
      r  = $urandom_range(0, 9);
      sz = (r == 9) ? 3'd3 : ((r < 6) ? 3'd2 : 3'($urandom_range(0, 1)));
      ln = 4'($urandom_range(0, 15));
      bt = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) begin
        a = 32'hFFC - 32'(4 * $urandom_range(0, 2)); sz = 3'd2; bt = 2'b01;
        ln = 4'($urandom_range(4, 15));
      end
      if ($urandom_range(0, 1) == 0) begin
        push_rand(int'(ln) + 1);
        write_burst(4'($urandom), a, ln, sz, bt, -1, $urandom_range(0, 2), 0);
      end else begin
        read_burst(4'($urandom), a, ln, sz, bt, 1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
